// File: rtl/fifo.sv
// fifo: 16x32 single-clock show-ahead FIFO staging data between DMA read and write sides
module fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic                  do_wr, do_rd;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign do_wr      = wen && !fifo_full;
  assign do_rd      = ren && !fifo_empty;
  assign data_out   = mem[rd_ptr[ADDR_WIDTH-1:0]];
  // pointer advance and storage; rst_n is active-high and clears everything immediately
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed and randomized checks of fifo against a queue reference model
module tb_fifo;
  logic        clk = 0, rst_n = 1, wen = 0, ren = 0;
  logic [31:0] data_in = 0, data_out;
  logic        fifo_full, fifo_empty;
  logic [31:0] q[$];
  int          n_cmp = 0, n_bad = 0;
  bit          last_wa, last_ra, full_seen;

  fifo dut (.clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .data_in(data_in),
            .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive at negedge, model the edge, check at the following negedge
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    wen = w; ren = r; data_in = d;
    last_wa = w && q.size() < 16;
    last_ra = r && q.size() != 0;
    if (last_ra) check("pop_data", data_out, q[0]);
    @(posedge clk);
    if (last_ra) void'(q.pop_front());
    if (last_wa) q.push_back(d);
    @(negedge clk);
    check("empty", {31'b0, fifo_empty}, {31'b0, q.size() == 0});
    check("full", {31'b0, fifo_full}, {31'b0, q.size() == 16});
    if (q.size() != 0) check("head", data_out, q[0]);
    if (fifo_full) full_seen = 1;
    wen = 0; ren = 0;
  endtask

  initial begin
    logic [31:0] nxt;
    int wr_sent, pops, wr_wait, rd_wait;
    @(negedge clk);
    check("rst_empty", {31'b0, fifo_empty}, 32'd1);
    check("rst_full", {31'b0, fifo_full}, 32'd0);
    rst_n = 0;
    // async reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 0, 32'h100 + i);
    #2 rst_n = 1;
    #1;
    q.delete();
    check("arst_empty", {31'b0, fifo_empty}, 32'd1);
    check("arst_full", {31'b0, fifo_full}, 32'd0);
    check("arst_dout", data_out, 32'd0);
    @(negedge clk);
    rst_n = 0;
    step(1, 0, 32'hA5A5A5A5);
    check("first_word", data_out, 32'hA5A5A5A5);
    step(0, 1, 0);
    // fill to full, overflow write ignored, drain in order
    for (int i = 1; i <= 16; i++) step(1, 0, i);
    check("fill_full", {31'b0, fifo_full}, 32'd1);
    step(1, 0, 32'hDEAD);
    for (int i = 1; i <= 16; i++) begin
      check("drain_val", data_out, i);
      step(0, 1, 0);
    end
    check("drain_empty", {31'b0, fifo_empty}, 32'd1);
    // underflow
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(1, 0, 32'h55);
    check("after_underflow", data_out, 32'h55);
    step(0, 1, 0);
    // simultaneous with 5 stored
    for (int i = 0; i < 5; i++) step(1, 0, 32'h200 + i);
    for (int i = 0; i < 10; i++) step(1, 1, 32'h300 + i);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    // simultaneous when empty: write only
    step(1, 1, 32'h77);
    check("sim_empty_head", data_out, 32'h77);
    step(0, 1, 0);
    // simultaneous when full: read only
    for (int i = 0; i < 16; i++) step(1, 0, 32'h400 + i);
    step(1, 1, 32'hBAD);
    check("sim_full_flag", {31'b0, fifo_full}, 32'd0);
    while (q.size() != 0) step(0, 1, 0);
    // random traffic across wraps
    full_seen = 0; wr_sent = 0; pops = 0; wr_wait = 0; rd_wait = 0;
    nxt = $urandom;
    for (int c = 0; c < 2000 && pops < 40; c++) begin
      step(wr_sent < 40 && wr_wait == 0, rd_wait == 0, nxt);
      if (last_wa) begin
        wr_sent++;
        nxt = $urandom;
      end
      pops += int'(last_ra);
      wr_wait = last_wa ? 1 : (wr_wait > 0 ? wr_wait - 1 : 0);
      rd_wait = last_ra ? 4 : (rd_wait > 0 ? rd_wait - 1 : 0);
    end
    check("rand_pops", pops, 40);
    check("rand_full_seen", {31'b0, full_seen}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
